period_meter: RTL and testbench
===============================

// Module: period_meter
// PURPOSE
//  Measures the period and high time of a square wave in I_CLK cycles: the inverse of the clock divider (MOD in -> clock out).
//  Recovers the MOD value from a divided clock, tone or key-strobe input.
//  Used for self-test of divider outputs and pitch/tempo checks on incoming audio-rate signals.
//  Averages 2**AVG_LOG2 periods per result.
//  Flags loss of signal with a timeout.
// PARAMETERS
//  CNT_W     16     width of period/high counters and outputs
//  AVG_LOG2  2      log2 of periods averaged per result (0 = every period)
//  TIMEOUT   65535  longest accepted period in I_CLK cycles; 2 <= TIMEOUT <= 2**CNT_W-1
// PORTS
//  I_CLK      in   1      system clock; all logic on posedge
//  I_RST      in   1      asynchronous, active-high reset
//  I_SIG      in   1      measured signal, asynchronous to I_CLK
//  O_PERIOD   out  CNT_W  averaged period in I_CLK cycles
//  O_HIGH     out  CNT_W  high time of the last period in the batch
//  O_VALID    out  1      one-cycle pulse when O_PERIOD/O_HIGH update
//  O_LOCKED   out  1      1 once a result exists since the last reset or timeout
//  O_TIMEOUT  out  1      level; 1 while no edge is seen for TIMEOUT cycles
// BEHAVIOUR
//  Reset:
//   - All outputs, counters, accumulator and sync/edge flops go to 0.
//   - State goes to IDLE immediately (async).
//  Input path:
//   - I_SIG goes through a 2-flop synchronizer, then a registered rise/fall detector.
//   - Edge pulse arrives 3 cycles after the I_SIG transition.
//  Period count:
//   - cnt clears to 0 on a rise cycle and increments otherwise.
//   - Period = cnt+1 on the next rise, so a /6 clock measures 6.
//   - hi counts cycles since rise until the fall; it is latched at the fall.
//  FSM:
//   - IDLE: first rise -> MEASURE.
//     - Clears cnt, acc, nper and O_TIMEOUT.
//     - Produces no output, so a spurious rise after reset is harmless.
//   - MEASURE, rise:
//     - acc += cnt+1 and nper++; hi_last <= latched hi.
//     - When nper reaches 2**AVG_LOG2:
//       - O_PERIOD <= acc_next >> AVG_LOG2 (truncate) and O_HIGH <= hi_last.
//       - O_VALID pulses 1 cycle after the rise-detect cycle; O_LOCKED <= 1.
//       - acc and nper clear.
//   - MEASURE, no rise, cnt == TIMEOUT-1 -> IDLE.
//     - O_TIMEOUT <= 1, O_LOCKED <= 0; partial batch discarded.
//     - O_PERIOD/O_HIGH hold their last values.
//  Boundaries:
//   - A rise on the cycle cnt == TIMEOUT-1 is a valid period of TIMEOUT; no timeout.
//   - cnt never exceeds TIMEOUT-1, so no overflow.
//   - acc is CNT_W+AVG_LOG2 bits and cannot wrap.
//   - No fall within a period (stuck high): hi saturates at cnt and O_HIGH = period.
//   - O_TIMEOUT clears on the first rise after it sets, which enters MEASURE.
//   - A reset in any state discards the batch; the next result needs 1+2**AVG_LOG2 rises.
//   - Minimum measurable period is 2; each phase must last >= 1 I_CLK cycle.
// STRUCTURE
//  Shared header meter_defs.vh:
//   - FSM state localparams (IDLE=1'b0, MEASURE=1'b1).
//   - Default CNT_W/TIMEOUT values.
//  Sub-module sync_edge:
//   - 2-flop synchronizer plus registered O_RISE/O_FALL pulses.
//   - Async active-high reset.
//   - Reusable for key inputs.
//  Top level holds the counters, accumulator, FSM and output registers.
// TESTING
//  1. I_SIG = /6 clock, AVG_LOG2=2 -> first O_VALID after 5th rise; O_PERIOD=6, O_HIGH=3, O_LOCKED=1.
//  2. I_SIG = /12288 clock -> O_PERIOD=12288, O_HIGH=6144 on every 4th rise.
//  3. Periods 5,6,6,6 (high 2 each), AVG_LOG2=2 -> O_PERIOD=5 (23>>2), O_HIGH=2.
//  4. TIMEOUT=100, I_SIG stops -> O_TIMEOUT=1 and O_LOCKED=0 exactly 100 cycles after last rise-detect; resume -> O_TIMEOUT=0 at next rise, relock after 4 more periods.
//  5. TIMEOUT=100, period exactly 100 -> O_PERIOD=100, O_TIMEOUT stays 0; period 101 -> timeout.
//  6. Assert I_RST mid-batch with I_SIG high -> all outputs 0 same cycle; after release no O_VALID before 5 rises.

Source files
------------

// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter: FSM state encoding and parameter defaults.
package period_meter_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  localparam int DEF_CNT_W    = 16;
  localparam int DEF_AVG_LOG2 = 2;
  localparam int DEF_TIMEOUT  = 65535;

endpackage

// File: rtl/period_meter_sync_edge.sv
// Two-flop synchronizer followed by a registered rise/fall detector.
// An I_SIG transition shows up as a one-cycle O_RISE/O_FALL pulse three clocks later.
module period_meter_sync_edge (
  input  logic I_CLK,
  input  logic I_RST,
  input  logic I_SIG,
  output logic O_RISE,
  output logic O_FALL
);

  logic sig_p0;
  logic sig_p1;
  logic sig_p2;

  // Synchronize the asynchronous input, then compare consecutive samples for edges
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      sig_p0 <= 1'b0;
      sig_p1 <= 1'b0;
      sig_p2 <= 1'b0;
      O_RISE <= 1'b0;
      O_FALL <= 1'b0;
    end else begin
      // stage p0/p1: metastability settling
      sig_p0 <= I_SIG;
      sig_p1 <= sig_p0;
      // stage p2: previous settled sample
      sig_p2 <= sig_p1;
      // stage p3: registered edge pulses
      O_RISE <= sig_p1 & ~sig_p2;
      O_FALL <= ~sig_p1 & sig_p2;
    end
  end

endmodule

// File: rtl/period_meter.sv
// Square-wave period / high-time meter. Counts I_CLK cycles between rising edges,
// averages 2**AVG_LOG2 periods per result and drops lock when no edge arrives
// within TIMEOUT cycles.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int AVG_LOG2 = DEF_AVG_LOG2,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic             I_CLK,
  input  logic             I_RST,
  input  logic             I_SIG,
  output logic [CNT_W-1:0] O_PERIOD,
  output logic [CNT_W-1:0] O_HIGH,
  output logic             O_VALID,
  output logic             O_LOCKED,
  output logic             O_TIMEOUT
);

  localparam int ACC_W  = CNT_W + AVG_LOG2;
  localparam int NPER_W = AVG_LOG2 + 1;
  localparam logic [NPER_W-1:0] BATCH    = NPER_W'(1) << AVG_LOG2;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic              rise_p3;
  logic              fall_p3;
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  hi_lat;
  logic [CNT_W-1:0]  hi_now;
  logic              fall_seen;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_next;
  logic [NPER_W-1:0] nper;
  logic [NPER_W-1:0] nper_next;

  period_meter_sync_edge u_sync_edge (
    .I_CLK  (I_CLK),
    .I_RST  (I_RST),
    .I_SIG  (I_SIG),
    .O_RISE (rise_p3),
    .O_FALL (fall_p3)
  );

  // Next-value arithmetic; a period with no fall counts as high for its whole length
  always_comb begin
    cnt_inc   = cnt + CNT_W'(1);
    hi_now    = fall_seen ? hi_lat : cnt_inc;
    acc_next  = acc + ACC_W'(cnt_inc);
    nper_next = nper + NPER_W'(1);
  end

  // Measurement FSM with counters, accumulator and registered outputs
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hi_lat    <= '0;
      fall_seen <= 1'b0;
      acc       <= '0;
      nper      <= '0;
      O_PERIOD  <= '0;
      O_HIGH    <= '0;
      O_VALID   <= 1'b0;
      O_LOCKED  <= 1'b0;
      O_TIMEOUT <= 1'b0;
    end else begin
      O_VALID <= 1'b0;
      if (state == ST_IDLE) begin
        // The first rise only opens a period; it never produces a result
        cnt       <= '0;
        acc       <= '0;
        nper      <= '0;
        fall_seen <= 1'b0;
        if (rise_p3) begin
          state     <= ST_MEASURE;
          O_TIMEOUT <= 1'b0;
        end
      end else if (rise_p3) begin
        // Rise closes a period of cnt+1 cycles, including a rise on cnt == TIMEOUT-1
        cnt       <= '0;
        fall_seen <= 1'b0;
        if (nper_next == BATCH) begin
          O_PERIOD <= acc_next[AVG_LOG2 +: CNT_W];
          O_HIGH   <= hi_now;
          O_VALID  <= 1'b1;
          O_LOCKED <= 1'b1;
          acc      <= '0;
          nper     <= '0;
        end else begin
          acc  <= acc_next;
          nper <= nper_next;
        end
      end else if (cnt == CNT_LAST) begin
        // Loss of signal: drop the partial batch, keep the last result visible
        state     <= ST_IDLE;
        cnt       <= '0;
        acc       <= '0;
        nper      <= '0;
        fall_seen <= 1'b0;
        O_TIMEOUT <= 1'b1;
        O_LOCKED  <= 1'b0;
      end else begin
        cnt <= cnt_inc;
        if (fall_p3) begin
          fall_seen <= 1'b1;
          hi_lat    <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: one instance with default TIMEOUT and one with
// TIMEOUT=100. Stimulus pushes expected results; per-instance monitors pop on O_VALID.
module tb_period_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        sig_a, sig_b;
  logic [15:0] per_a, hi_a, per_b, hi_b;
  logic        vld_a, lck_a, to_a;
  logic        vld_b, lck_b, to_b;

  always #5 clk = ~clk;

  period_meter #(.CNT_W(16), .AVG_LOG2(2), .TIMEOUT(65535)) dut_a (
    .I_CLK(clk), .I_RST(rst), .I_SIG(sig_a),
    .O_PERIOD(per_a), .O_HIGH(hi_a), .O_VALID(vld_a),
    .O_LOCKED(lck_a), .O_TIMEOUT(to_a)
  );

  period_meter #(.CNT_W(16), .AVG_LOG2(2), .TIMEOUT(100)) dut_b (
    .I_CLK(clk), .I_RST(rst), .I_SIG(sig_b),
    .O_PERIOD(per_b), .O_HIGH(hi_b), .O_VALID(vld_b),
    .O_LOCKED(lck_b), .O_TIMEOUT(to_b)
  );

  typedef struct packed {
    int per;
    int hi;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Hand-computed results for instance A, one per batch of four periods
  int ea_per[5] = '{6, 6, 5, 7, 12288};
  int ea_hi[5]  = '{3, 3, 2, 1, 6144};
  // Period / high-time of each period driven into instance A
  int tp_a[21] = '{6, 6, 6, 6, 6, 6, 6, 6, 5, 6, 6, 6, 7, 9, 10, 2,
                   12288, 12288, 12288, 12288, 6};
  int th_a[21] = '{3, 3, 3, 3, 3, 3, 3, 3, 2, 2, 2, 2, 1, 8, 5, 1,
                   6144, 6144, 6144, 6144, 3};

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Wait n rising edges, then settle 1 time unit past the edge
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cyc_a(input int p, input int h);
    sig_a = 1'b1;
    edges(h);
    sig_a = 1'b0;
    edges(p - h);
  endtask

  task automatic cyc_b(input int p, input int h);
    sig_b = 1'b1;
    edges(h);
    sig_b = 1'b0;
    edges(p - h);
  endtask

  // Monitor A
  always @(negedge clk) begin
    exp_t e;
    if (vld_a) begin
      if (q_a.size() == 0) chk("a_unexpected_valid", 1, 0);
      else begin
        e = q_a.pop_front();
        chk("a_period", int'(per_a), e.per);
        chk("a_high", int'(hi_a), e.hi);
        chk("a_locked", int'(lck_a), 1);
      end
    end
  end

  // Monitor B
  always @(negedge clk) begin
    exp_t e;
    if (vld_b) begin
      if (q_b.size() == 0) chk("b_unexpected_valid", 1, 0);
      else begin
        e = q_b.pop_front();
        chk("b_period", int'(per_b), e.per);
        chk("b_high", int'(hi_b), e.hi);
        chk("b_locked", int'(lck_b), 1);
        chk("b_timeout_at_valid", int'(to_b), 0);
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    rst   = 1'b1;
    sig_a = 1'b0;
    sig_b = 1'b0;
    edges(3);
    chk("rst_a_period", int'(per_a), 0);
    chk("rst_a_high", int'(hi_a), 0);
    chk("rst_a_valid", int'(vld_a), 0);
    chk("rst_a_locked", int'(lck_a), 0);
    chk("rst_a_timeout", int'(to_a), 0);
    chk("rst_b_timeout", int'(to_b), 0);
    rst = 1'b0;
    edges(2);

    fork
      begin
        // Instance A: /6, mixed periods, minimum period, /12288
        for (int i = 1; i <= 21; i++) begin
          if (i >= 5 && (i - 1) % 4 == 0)
            q_a.push_back('{ea_per[(i - 5) / 4], ea_hi[(i - 5) / 4]});
          cyc_a(tp_a[i - 1], th_a[i - 1]);
        end
        chk("a_locked_after_runs", int'(lck_a), 1);
        chk("a_no_timeout", int'(to_a), 0);
      end
      begin
        // Instance B: lock at /10, then loss of signal exactly 100 cycles after the last rise
        for (int i = 1; i <= 8; i++) begin
          if (i == 5) q_b.push_back('{10, 5});
          cyc_b(10, 5);
        end
        q_b.push_back('{10, 5});
        sig_b = 1'b1;
        edges(5);
        sig_b = 1'b0;
        edges(98);
        chk("b_timeout_before", int'(to_b), 0);
        chk("b_locked_before", int'(lck_b), 1);
        edges(1);
        chk("b_timeout_set", int'(to_b), 1);
        chk("b_locked_clear", int'(lck_b), 0);
        chk("b_period_hold", int'(per_b), 10);
        chk("b_high_hold", int'(hi_b), 5);
        edges(10);
        // Resume: timeout clears on the rise that re-enters measurement
        sig_b = 1'b1;
        edges(3);
        chk("b_timeout_still_set", int'(to_b), 1);
        edges(1);
        chk("b_timeout_cleared", int'(to_b), 0);
        chk("b_not_relocked", int'(lck_b), 0);
        edges(3);
        sig_b = 1'b0;
        edges(13);
        for (int i = 2; i <= 4; i++) cyc_b(20, 7);
        chk("b_still_unlocked", int'(lck_b), 0);
        q_b.push_back('{20, 7});
        for (int i = 5; i <= 8; i++) cyc_b(100, 50);
        // Period of exactly TIMEOUT is accepted
        q_b.push_back('{100, 50});
        sig_b = 1'b1;
        edges(50);
        sig_b = 1'b0;
        chk("b_period100_no_timeout", int'(to_b), 0);
        chk("b_period100_locked", int'(lck_b), 1);
        // Period of TIMEOUT+1 times out before its rise is seen
        edges(51);
        sig_b = 1'b1;
        edges(3);
        chk("b_period101_timeout", int'(to_b), 1);
        chk("b_period101_unlocked", int'(lck_b), 0);
        edges(1);
        chk("b_late_rise_clears", int'(to_b), 0);
        edges(5);
        sig_b = 1'b0;
      end
    join

    // Reset mid-batch with the input high
    cyc_a(6, 3);
    cyc_a(6, 3);
    sig_a = 1'b1;
    edges(2);
    chk("pre_rst_a_locked", int'(lck_a), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_a_period", int'(per_a), 0);
    chk("mid_rst_a_high", int'(hi_a), 0);
    chk("mid_rst_a_locked", int'(lck_a), 0);
    chk("mid_rst_a_valid", int'(vld_a), 0);
    chk("mid_rst_b_period", int'(per_b), 0);
    chk("mid_rst_b_high", int'(hi_b), 0);
    chk("mid_rst_b_timeout", int'(to_b), 0);
    sig_a = 1'b0;
    edges(3);
    rst = 1'b0;
    edges(2);
    for (int i = 1; i <= 8; i++) begin
      if (i == 5) begin
        chk("post_rst_a_unlocked", int'(lck_a), 0);
        q_a.push_back('{6, 3});
      end
      cyc_a(6, 3);
    end
    chk("post_rst_a_locked", int'(lck_a), 1);
    edges(10);
    chk("a_queue_drained", q_a.size(), 0);
    chk("b_queue_drained", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
